// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int PC_WIDTH            = 30;
    localparam int INSTR_WIDTH         = 32;
    localparam int BRANCH_OFFSET_WIDTH = 16;
    localparam int JUMP_FIELD_WIDTH    = 26;
    localparam int SEXT_WIDTH          = PC_WIDTH - BRANCH_OFFSET_WIDTH;
    localparam int JUMP_REGION_WIDTH   = PC_WIDTH - JUMP_FIELD_WIDTH;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    // Widens a signed 16-bit word offset to a full PC-width addend.
    function automatic logic [PC_WIDTH-1:0] sign_extend_offset(
        input logic [BRANCH_OFFSET_WIDTH-1:0] offset
    );
        return {{SEXT_WIDTH{offset[BRANCH_OFFSET_WIDTH-1]}}, offset};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: instruction memory port plus the decode handshake and redirect inputs.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [PC_WIDTH-1:0]            imem_addr;
    logic [INSTR_WIDTH-1:0]         imem_rdata;
    logic                           instr_valid;
    logic [INSTR_WIDTH-1:0]         instr;
    logic [PC_WIDTH-1:0]            instr_pc;
    logic                           decode_ready;
    logic                           branch_taken;
    logic [BRANCH_OFFSET_WIDTH-1:0] branch_offset;
    logic                           jump_taken;
    logic [JUMP_FIELD_WIDTH-1:0]    jump_target;

    // Fetch unit side.
    modport master (
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        output instr,
        output instr_pc,
        input  decode_ready,
        input  branch_taken,
        input  branch_offset,
        input  jump_taken,
        input  jump_target
    );

    // Memory / decode side.
    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output decode_ready,
        output branch_taken,
        output branch_offset,
        output jump_taken,
        output jump_target
    );

endinterface

// File: rtl/FullAdder30.sv
// 30-bit ripple-carry adder used for every next-PC computation; the carry out of
// the top bit is dropped so all PC arithmetic wraps modulo 2^30.
module FullAdder30
    import instruction_fetch_unit_pkg::*;
(
    input  logic [PC_WIDTH-1:0] a,
    input  logic [PC_WIDTH-1:0] b,
    input  logic                cin,
    output logic [PC_WIDTH-1:0] sum
);

    logic [PC_WIDTH-1:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < PC_WIDTH; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < PC_WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory and hands
// instructions to decode over valid/ready, honouring branch and jump redirects.
//
// pc_q is the address currently presented to memory; its data arrives on
// imem_rdata one cycle later. While an instruction is presented, pc_q is always
// instr_pc + 1, so RUN can pass imem_rdata straight through and the jump region
// bits come from pc_q without another adder.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  fetch_bus
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;

    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [PC_WIDTH-1:0]    branch_offset_ext;
    logic [PC_WIDTH-1:0]    branch_target;
    logic [PC_WIDTH-1:0]    jump_target_pc;
    logic [PC_WIDTH-1:0]    redirect_target;
    logic                   presenting;
    logic                   transfer;
    logic                   redirect;

    assign presenting        = (state_q == RUN) || (state_q == HOLD);
    assign transfer          = presenting && fetch_bus.decode_ready;
    assign redirect          = transfer && (fetch_bus.branch_taken || fetch_bus.jump_taken);
    assign branch_offset_ext = sign_extend_offset(fetch_bus.branch_offset);
    assign jump_target_pc    = {pc_q[PC_WIDTH-1 -: JUMP_REGION_WIDTH], fetch_bus.jump_target};
    assign redirect_target   = fetch_bus.jump_taken ? jump_target_pc : branch_target;

    FullAdder30 u_pc_inc (
        .a   (pc_q),
        .b   ({PC_WIDTH{1'b0}}),
        .cin (1'b1),
        .sum (pc_plus1)
    );

    FullAdder30 u_branch_add (
        .a   (instr_pc_q),
        .b   (branch_offset_ext),
        .cin (1'b1),
        .sum (branch_target)
    );

    // State register; reset parks the unit in START with the first read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirects only count on a transfer, a stalled RUN parks in HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            START, FLUSH: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    state_d = FLUSH;
                end else if (!transfer) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = FLUSH;
                end else if (transfer) begin
                    state_d = RUN;
                end
            end
            default: state_d = START;
        endcase
    end

    // Outputs: RUN shows the word arriving from memory, HOLD replays the captured one.
    always_comb begin
        fetch_bus.instr_valid = 1'b0;
        fetch_bus.instr       = '0;
        case (state_q)
            RUN: begin
                fetch_bus.instr_valid = 1'b1;
                fetch_bus.instr       = fetch_bus.imem_rdata;
            end
            HOLD: begin
                fetch_bus.instr_valid = 1'b1;
                fetch_bus.instr       = hold_q;
            end
            default: begin
                fetch_bus.instr_valid = 1'b0;
                fetch_bus.instr       = '0;
            end
        endcase
    end

    assign fetch_bus.imem_addr = pc_q;
    assign fetch_bus.instr_pc  = instr_pc_q;

    // Datapath next values: advance on transfer, retarget on redirect, freeze on stall.
    always_comb begin
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        hold_d     = hold_q;
        case (state_q)
            START, FLUSH: begin
                instr_pc_d = pc_q;
                pc_d       = pc_plus1;
            end
            RUN, HOLD: begin
                if (redirect) begin
                    pc_d   = redirect_target;
                    hold_d = '0;
                end else if (transfer) begin
                    instr_pc_d = pc_q;
                    pc_d       = pc_plus1;
                end else if (state_q == RUN) begin
                    hold_d = fetch_bus.imem_rdata;
                end
            end
            default: begin
                pc_d = RESET_PC;
            end
        endcase
    end

    // Datapath registers: fetch address, presented instruction address, stall buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            hold_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Three instances share clock and reset:
// the main one (RESET_PC=0), one starting just below the 2^30 wrap, and one starting
// in jump region 1. Each memory model returns {addr, 2'b00} one cycle after the address.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    instruction_fetch_unit_if if_main ();
    instruction_fetch_unit_if if_wrap ();
    instruction_fetch_unit_if if_jump ();

    instruction_fetch_unit #(.RESET_PC(30'h0000_0000)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (if_main)
    );

    instruction_fetch_unit #(.RESET_PC(30'h3FFF_FFFE)) u_dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (if_wrap)
    );

    instruction_fetch_unit #(.RESET_PC(30'h0400_0010)) u_dut_jump (
        .clk       (clk),
        .reset     (reset),
        .fetch_bus (if_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memories: data for an address appears the next cycle.
    always @(posedge clk) if_main.imem_rdata <= {if_main.imem_addr, 2'b00};
    always @(posedge clk) if_wrap.imem_rdata <= {if_wrap.imem_addr, 2'b00};
    always @(posedge clk) if_jump.imem_rdata <= {if_jump.imem_addr, 2'b00};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges and releases it mid-cycle; the unit is then in START.
    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_compared++;
        if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b0, 30'h0, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%b pc=%h instr=%h, expected valid=0 pc=0 instr=0",
                     if_main.instr_valid, if_main.instr_pc, if_main.instr);
        end
        n_compared++;
        if (if_main.imem_addr !== 30'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_imem_addr: got %h, expected 00000000", if_main.imem_addr);
        end
        n_compared++;
        if (if_wrap.imem_addr !== 30'h3FFF_FFFE) begin
            n_mismatched++;
            $display("[TB] FAIL reset_imem_addr_wrap: got %h, expected 3ffffffe", if_wrap.imem_addr);
        end
        reset = 1'b0;
        #1;
        n_compared++;
        if ({if_main.instr_valid, if_main.imem_addr} !== {1'b0, 30'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL start_state: got valid=%b addr=%h, expected valid=0 addr=0",
                     if_main.instr_valid, if_main.imem_addr);
        end
    endtask

    // Free-running fetch from reset: pc 0..5 on consecutive cycles, instr = pc*4.
    task automatic test_sequential();
        logic [PC_WIDTH-1:0] exp_pc;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_pc = PC_WIDTH'(i);
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, exp_pc, exp_pc, 2'b00}) begin
                n_mismatched++;
                $display("[TB] FAIL seq[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                         i, if_main.instr_valid, if_main.instr_pc, if_main.instr, exp_pc, {exp_pc, 2'b00});
            end
        end
    endtask

    // Stall three cycles at pc 5, then release: 5 is held, followed by 6 and 7.
    task automatic test_stall();
        logic [PC_WIDTH-1:0] exp_pc;
        if_main.decode_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, 30'd5, 32'd20}) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=5 instr=14",
                         k, if_main.instr_valid, if_main.instr_pc, if_main.instr);
            end
            n_compared++;
            if (if_main.imem_addr !== 30'd6) begin
                n_mismatched++;
                $display("[TB] FAIL stall_addr[%0d]: got %h, expected 00000006", k, if_main.imem_addr);
            end
        end
        if_main.decode_ready = 1'b1;
        for (int n = 6; n < 8; n++) begin
            step();
            exp_pc = PC_WIDTH'(n);
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, exp_pc, exp_pc, 2'b00}) begin
                n_mismatched++;
                $display("[TB] FAIL stall_release[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h",
                         n, if_main.instr_valid, if_main.instr_pc, if_main.instr, exp_pc);
            end
        end
    endtask

    // Branch at pc 10 by -4: one bubble with imem_addr=7, then 7 and 8; 11 never shown.
    task automatic test_branch();
        logic [PC_WIDTH-1:0] exp_pc;
        for (int n = 8; n < 11; n++) begin
            step();
            exp_pc = PC_WIDTH'(n);
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc} !== {1'b1, exp_pc}) begin
                n_mismatched++;
                $display("[TB] FAIL pre_branch[%0d]: got valid=%b pc=%h, expected valid=1 pc=%h",
                         n, if_main.instr_valid, if_main.instr_pc, exp_pc);
            end
        end
        if_main.branch_taken  = 1'b1;
        if_main.branch_offset = 16'hFFFC;
        step();
        if_main.branch_taken  = 1'b0;
        if_main.branch_offset = 16'h0000;
        n_compared++;
        if ({if_main.instr_valid, if_main.imem_addr} !== {1'b0, 30'd7}) begin
            n_mismatched++;
            $display("[TB] FAIL branch_bubble: got valid=%b addr=%h, expected valid=0 addr=00000007",
                     if_main.instr_valid, if_main.imem_addr);
        end
        for (int n = 7; n < 9; n++) begin
            step();
            exp_pc = PC_WIDTH'(n);
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, exp_pc, exp_pc, 2'b00}) begin
                n_mismatched++;
                $display("[TB] FAIL branch_target[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h",
                         n, if_main.instr_valid, if_main.instr_pc, if_main.instr, exp_pc);
            end
        end
    endtask

    // Branch during a stall is ignored; a jump on the HOLD transfer redirects to 0x20.
    task automatic test_redirect_from_hold();
        if_main.decode_ready  = 1'b0;
        if_main.branch_taken  = 1'b1;
        if_main.branch_offset = 16'h0005;
        step();
        n_compared++;
        if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, 30'd8, 32'd32}) begin
            n_mismatched++;
            $display("[TB] FAIL ignored_branch: got valid=%b pc=%h instr=%h, expected valid=1 pc=8 instr=20",
                     if_main.instr_valid, if_main.instr_pc, if_main.instr);
        end
        if_main.decode_ready  = 1'b1;
        if_main.branch_taken  = 1'b0;
        if_main.branch_offset = 16'h0000;
        if_main.jump_taken    = 1'b1;
        if_main.jump_target   = 26'h000_0020;
        step();
        if_main.jump_taken    = 1'b0;
        if_main.jump_target   = 26'h0;
        n_compared++;
        if ({if_main.instr_valid, if_main.imem_addr} !== {1'b0, 30'h20}) begin
            n_mismatched++;
            $display("[TB] FAIL hold_jump_bubble: got valid=%b addr=%h, expected valid=0 addr=00000020",
                     if_main.instr_valid, if_main.imem_addr);
        end
        step();
        n_compared++;
        if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, 30'h20, 32'h80}) begin
            n_mismatched++;
            $display("[TB] FAIL hold_jump_target: got valid=%b pc=%h instr=%h, expected valid=1 pc=20 instr=80",
                     if_main.instr_valid, if_main.instr_pc, if_main.instr);
        end
        step();
        n_compared++;
        if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, 30'h21, 32'h84}) begin
            n_mismatched++;
            $display("[TB] FAIL hold_jump_next: got valid=%b pc=%h instr=%h, expected valid=1 pc=21 instr=84",
                     if_main.instr_valid, if_main.instr_pc, if_main.instr);
        end
    endtask

    // Wrap instance counts 3FFFFFFE, 3FFFFFFF, 0, 1; jump instance takes the jump
    // (not the branch) at 04000010 and lands on 04000040.
    task automatic test_wrap_and_jump();
        logic [PC_WIDTH-1:0] wrap_seq [4];
        wrap_seq[0] = 30'h3FFF_FFFE;
        wrap_seq[1] = 30'h3FFF_FFFF;
        wrap_seq[2] = 30'h0000_0000;
        wrap_seq[3] = 30'h0000_0001;
        pulse_reset();
        if_jump.jump_taken    = 1'b1;
        if_jump.branch_taken  = 1'b1;
        if_jump.branch_offset = 16'h0005;
        if_jump.jump_target   = 26'h000_0040;
        for (int i = 0; i < 4; i++) begin
            step();
            n_compared++;
            if ({if_wrap.instr_valid, if_wrap.instr_pc, if_wrap.instr} !== {1'b1, wrap_seq[i], wrap_seq[i], 2'b00}) begin
                n_mismatched++;
                $display("[TB] FAIL wrap[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                         i, if_wrap.instr_valid, if_wrap.instr_pc, if_wrap.instr, wrap_seq[i], {wrap_seq[i], 2'b00});
            end
            if (i == 0) begin
                n_compared++;
                if ({if_jump.instr_valid, if_jump.instr_pc, if_jump.instr} !== {1'b1, 30'h0400_0010, 32'h1000_0040}) begin
                    n_mismatched++;
                    $display("[TB] FAIL jump_source: got valid=%b pc=%h instr=%h, expected valid=1 pc=04000010 instr=10000040",
                             if_jump.instr_valid, if_jump.instr_pc, if_jump.instr);
                end
            end else if (i == 1) begin
                if_jump.jump_taken    = 1'b0;
                if_jump.branch_taken  = 1'b0;
                if_jump.branch_offset = 16'h0000;
                if_jump.jump_target   = 26'h0;
                n_compared++;
                if ({if_jump.instr_valid, if_jump.imem_addr} !== {1'b0, 30'h0400_0040}) begin
                    n_mismatched++;
                    $display("[TB] FAIL jump_bubble: got valid=%b addr=%h, expected valid=0 addr=04000040",
                             if_jump.instr_valid, if_jump.imem_addr);
                end
            end else if (i == 2) begin
                n_compared++;
                if ({if_jump.instr_valid, if_jump.instr_pc, if_jump.instr} !== {1'b1, 30'h0400_0040, 32'h1000_0100}) begin
                    n_mismatched++;
                    $display("[TB] FAIL jump_priority: got valid=%b pc=%h instr=%h, expected valid=1 pc=04000040 instr=10000100",
                             if_jump.instr_valid, if_jump.instr_pc, if_jump.instr);
                end
            end
        end
    endtask

    // Reset asserted between edges while in HOLD clears outputs at once; fetch restarts at 0.
    task automatic test_async_reset();
        logic [PC_WIDTH-1:0] exp_pc;
        pulse_reset();
        if_main.decode_ready = 1'b1;
        repeat (3) step();
        if_main.decode_ready = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        n_compared++;
        if ({if_main.instr_valid, if_main.instr} !== {1'b0, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset_outputs: got valid=%b instr=%h, expected valid=0 instr=0",
                     if_main.instr_valid, if_main.instr);
        end
        n_compared++;
        if (if_main.imem_addr !== 30'h0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset_addr: got %h, expected 00000000", if_main.imem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        if_main.decode_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            step();
            exp_pc = PC_WIDTH'(n);
            n_compared++;
            if ({if_main.instr_valid, if_main.instr_pc, if_main.instr} !== {1'b1, exp_pc, exp_pc, 2'b00}) begin
                n_mismatched++;
                $display("[TB] FAIL restart[%0d]: got valid=%b pc=%h instr=%h, expected valid=1 pc=%h",
                         n, if_main.instr_valid, if_main.instr_pc, if_main.instr, exp_pc);
            end
        end
    endtask

    // Guards against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        if_main.decode_ready  = 1'b1;
        if_main.branch_taken  = 1'b0;
        if_main.branch_offset = 16'h0;
        if_main.jump_taken    = 1'b0;
        if_main.jump_target   = 26'h0;
        if_wrap.decode_ready  = 1'b1;
        if_wrap.branch_taken  = 1'b0;
        if_wrap.branch_offset = 16'h0;
        if_wrap.jump_taken    = 1'b0;
        if_wrap.jump_target   = 26'h0;
        if_jump.decode_ready  = 1'b1;
        if_jump.branch_taken  = 1'b0;
        if_jump.branch_offset = 16'h0;
        if_jump.jump_taken    = 1'b0;
        if_jump.jump_target   = 26'h0;

        $display("[TB] starting instruction_fetch_unit bench");
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_redirect_from_hold();
        test_wrap_and_jump();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
